axi_mem_tester: RTL and testbench

Parametrised AXI4 memory-test master, next generation of the NoC/DDR traffic generator. It writes a seeded, deterministic pattern across a configurable region, reads it back, compares every beat and reports busy/done/pass plus a saturating error count. It sits between the fabric clock domain and a NoC slave port (DDRMC behind it). Width, burst length, burst count, base address and run mode are all configurable.

---
 rtl/axi_mem_tester.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_tester.sv
// AXI4 memory-test master: writes a seeded pattern over a region, reads it
// back, compares every beat and reports busy/done/pass plus an error count.
module axi_mem_tester #(
    parameter int          DATA_W     = 128,
    parameter int          ADDR_W     = 64,
    parameter int          ID_W       = 2,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 64,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          ERR_CNT_W  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    // write address
    output logic                   awvalid,
    input  logic                   awready,
    output logic [ADDR_W-1:0]      awaddr,
    output logic [7:0]             awlen,
    output logic [2:0]             awsize,
    output logic [1:0]             awburst,
    output logic [ID_W-1:0]        awid,
    output logic [3:0]             awcache,
    output logic [2:0]             awprot,
    output logic                   awlock,
    output logic [3:0]             awqos,
    output logic [3:0]             awregion,
    // write data
    output logic                   wvalid,
    input  logic                   wready,
    output logic [DATA_W-1:0]      wdata,
    output logic [DATA_W/8-1:0]    wstrb,
    output logic                   wlast,
    // write response
    input  logic                   bvalid,
    output logic                   bready,
    input  logic [1:0]             bresp,
    input  logic [ID_W-1:0]        bid,
    // read address
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_W-1:0]      araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic [ID_W-1:0]        arid,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    output logic                   arlock,
    output logic [3:0]             arqos,
    output logic [3:0]             arregion,
    // read data
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic [ID_W-1:0]        rid
);

    localparam int LANES       = DATA_W / 32;
    localparam int BYTES       = DATA_W / 8;
    localparam int BURST_BYTES = BURST_LEN * BYTES;
    localparam int SIZE        = $clog2(BYTES);
    localparam int BEAT_W      = $clog2(BURST_LEN + 1);
    localparam int BCNT_W      = $clog2(NUM_BURSTS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t              state, state_nx;
    logic                start_q;
    logic [1:0]          run_mode;
    logic [31:0]         seed_r;
    logic [BCNT_W-1:0]   burst_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [31:0]         beat_idx;
    logic [31:0]         lane_base;
    logic [DATA_W-1:0]   pat;
    logic [ADDR_W-1:0]   addr;
    logic                start_ok, last_beat, last_burst, wr_only;
    logic                r_bad, r_end, err_inc;
    logic                unused;

    // IDs are never checked; they are all driven 0 on the request side.
    assign unused = ^{bid, rid};

    assign start_ok   = start && !start_q && (state == S_IDLE || state == S_DONE);
    assign last_beat  = (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (burst_cnt == BCNT_W'(NUM_BURSTS - 1));
    assign wr_only    = (run_mode == 2'd1);

    // Global beat index drives the pattern for both the write and compare side.
    assign beat_idx  = 32'(burst_cnt) * 32'(BURST_LEN) + 32'(beat_cnt);
    assign lane_base = seed_r + beat_idx * 32'(LANES);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign pat[g*32 +: 32] = lane_base + 32'(g);
    end

    // An early rlast ends the burst; a missing one ends it after BURST_LEN beats.
    assign r_bad   = (rdata != pat) || (rresp != 2'b00) || (rlast != last_beat);
    assign r_end   = rlast || last_beat;
    assign err_inc = (state == S_WR_RESP && bvalid && bresp != 2'b00) ||
                     (state == S_RD_DATA && rvalid && r_bad);

    assign addr = ADDR_W'(BASE_ADDR) + ADDR_W'(burst_cnt) * ADDR_W'(BURST_BYTES);

    assign awaddr   = addr;
    assign awlen    = 8'(BURST_LEN - 1);
    assign awsize   = 3'(SIZE);
    assign awburst  = 2'b01;
    assign awid     = '0;
    assign awcache  = 4'b0011;
    assign awprot   = 3'b000;
    assign awlock   = 1'b0;
    assign awqos    = 4'h0;
    assign awregion = 4'h0;
    assign araddr   = addr;
    assign arlen    = 8'(BURST_LEN - 1);
    assign arsize   = 3'(SIZE);
    assign arburst  = 2'b01;
    assign arid     = '0;
    assign arcache  = 4'b0011;
    assign arprot   = 3'b000;
    assign arlock   = 1'b0;
    assign arqos    = 4'h0;
    assign arregion = 4'h0;
    assign wdata    = pat;
    assign wstrb    = '1;

    // State register; reset aborts any run immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state: one burst outstanding, write phase then read phase.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) state_nx = (mode == 2'd2) ? S_RD_ADDR : S_WR_ADDR;
            S_WR_ADDR:      if (awready) state_nx = S_WR_DATA;
            S_WR_DATA:      if (wready && last_beat) state_nx = S_WR_RESP;
            S_WR_RESP: begin
                if (bvalid) begin
                    if (!last_burst)  state_nx = S_WR_ADDR;
                    else if (wr_only) state_nx = S_DONE;
                    else              state_nx = S_RD_ADDR;
                end
            end
            S_RD_ADDR:      if (arready) state_nx = S_RD_DATA;
            S_RD_DATA:      if (rvalid && r_end) state_nx = last_burst ? S_DONE : S_RD_ADDR;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register, so valids are glitch-free.
    always_comb begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            S_WR_ADDR: awvalid = 1'b1;
            S_WR_DATA: begin wvalid = 1'b1; wlast = last_beat; end
            S_WR_RESP: bready  = 1'b1;
            S_RD_ADDR: arvalid = 1'b1;
            S_RD_DATA: rready  = 1'b1;
            S_DONE:    begin busy = 1'b0; done = 1'b1; end
            default:   busy = 1'b0;
        endcase
        pass = done && (err_cnt == '0);
    end

    // Run context, beat/burst counters and saturating error counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_q   <= 1'b0;
            run_mode  <= 2'd0;
            seed_r    <= 32'h0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            start_q <= start;
            if (start_ok) begin
                run_mode  <= mode;
                seed_r    <= seed;
                burst_cnt <= '0;
                beat_cnt  <= '0;
                err_cnt   <= '0;
            end else begin
                if (err_inc && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                case (state)
                    S_WR_DATA: if (wready) beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
                    S_WR_RESP: if (bvalid) burst_cnt <= last_burst ? '0 : burst_cnt + BCNT_W'(1);
                    S_RD_DATA: begin
                        if (rvalid) begin
                            beat_cnt <= r_end ? '0 : beat_cnt + BEAT_W'(1);
                            if (r_end) burst_cnt <= last_burst ? '0 : burst_cnt + BCNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: AXI slave memory with stall/fault knobs, a
// spec-level transfer/error model, and directed runs with literal expectations.
module tb_axi_mem_tester;

    localparam int DATA_W  = 128;
    localparam int ADDR_W  = 64;
    localparam int ID_W    = 2;
    localparam int BL      = 4;
    localparam int NB      = 2;
    localparam int ECW     = 2;
    localparam int LANES   = DATA_W / 32;
    localparam int BYTES   = DATA_W / 8;
    localparam int ERR_MAX = (1 << ECW) - 1;
    // {len, size, burst, cache, prot, lock, qos, region, id}
    localparam logic [30:0] AX_STATIC = {8'd3, 3'd4, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0, 2'd0};

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [31:0] seed = 32'h0;
    logic busy, done, pass;
    logic [ECW-1:0] err_cnt;
    logic awvalid, awlock, wvalid, wlast, bready, arvalid, arlock, rready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst;
    logic [ID_W-1:0] awid, arid;
    logic [ID_W-1:0] bid = '0, rid = '0;
    logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata = '0;
    logic [BYTES-1:0] wstrb;
    logic [1:0] bresp = 2'b00, rresp = 2'b00;

    always #5 aclk = ~aclk;

    axi_mem_tester #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .BURST_LEN(BL),
        .NUM_BURSTS(NB), .BASE_ADDR(64'h0), .ERR_CNT_W(ECW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid), .awcache(awcache),
        .awprot(awprot), .awlock(awlock), .awqos(awqos), .awregion(awregion),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid), .arcache(arcache),
        .arprot(arprot), .arlock(arlock), .arqos(arqos), .arregion(arregion),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pattern straight from the rule: lane i of beat k = seed + k*LANES + i.
    function automatic logic [DATA_W-1:0] beat_data(logic [31:0] sd, int k);
        logic [DATA_W-1:0] d = '0;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = sd + 32'(k * LANES + i);
        return d;
    endfunction

    // ---------------- slave memory with knobs ----------------
    bit stall = 0, early_rlast = 0, bresp_err0 = 0, zero_data = 0;
    int flip_beat = -1;
    logic [DATA_W-1:0] mem [0:NB*BL-1];
    logic [ADDR_W-1:0] aw_log [$];
    logic [ADDR_W-1:0] cur_waddr = '0, cur_raddr = '0;
    int s_wbeat = 0, s_rbeat = 0, s_rtotal = 0, s_rburst = 0, s_bcount = 0, s_arcount = 0, s_i = 0;
    bit b_todo = 0, r_active = 0, b_hs = 0, r_hs = 0;

    function automatic bit go();
        return !stall || ($urandom_range(0, 2) != 0);
    endfunction

    // Drives at negedge; a handshake seen here completes at the next posedge.
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                b_todo = 0; r_active = 0; b_hs = 0; r_hs = 0; s_wbeat = 0; s_rbeat = 0;
                continue;
            end
            if (b_hs) bvalid = 0;
            if (!bvalid && b_todo && go()) begin
                bvalid = 1;
                bresp = (bresp_err0 && s_bcount == 0) ? 2'b10 : 2'b00;
            end
            b_hs = bvalid && bready;
            if (b_hs) begin b_todo = 0; s_bcount++; end

            wready = go();
            if (wvalid && wready) begin
                s_i = int'(cur_waddr / BYTES) + s_wbeat;
                if (s_i >= 0 && s_i < NB*BL) mem[s_i] = wdata;
                s_wbeat++;
                if (s_wbeat == BL) begin s_wbeat = 0; b_todo = 1; end
            end

            awready = go();
            if (awvalid && awready) begin cur_waddr = awaddr; aw_log.push_back(awaddr); end

            if (r_hs) begin rvalid = 0; rlast = 0; end
            if (!rvalid && r_active && go()) begin
                rvalid = 1;
                rresp = 2'b00;
                rlast = (s_rbeat == BL-1) || (early_rlast && s_rburst == 0 && s_rbeat == 1);
                s_i = int'(cur_raddr / BYTES) + s_rbeat;
                rdata = (s_i >= 0 && s_i < NB*BL) ? mem[s_i] : '0;
                if (zero_data) rdata = '0;
                if (s_rtotal == flip_beat) rdata[0] = ~rdata[0];
            end
            r_hs = rvalid && rready;
            if (r_hs) begin
                s_rtotal++; s_rbeat++;
                if (rlast) begin s_rbeat = 0; s_rburst++; r_active = 0; end
            end

            arready = go();
            if (arvalid && arready) begin cur_raddr = araddr; r_active = 1; s_arcount++; end
        end
    end

    // ---------------- model and per-cycle compare ----------------
    int m_aw = 0, m_w = 0, m_ar = 0, m_rburst = 0, m_rbeat = 0, m_err = 0;
    logic [31:0] m_seed = 32'h0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_wlast = 0;
    logic [ADDR_W-1:0] p_awaddr = '0, p_araddr = '0;
    logic [DATA_W-1:0] p_wdata = '0;
    bit m_bad;

    initial begin
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin p_awv = 0; p_wv = 0; p_arv = 0; continue; end
            if (busy) check("err_cnt_track", err_cnt, m_err);
            check("one_channel", int'(awvalid) + int'(wvalid) + int'(bready) + int'(arvalid) + int'(rready), busy);
            if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
            if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (wvalid) check("w_after_aw", (m_w / BL) < m_aw, 1'b1);
            if (awvalid && awready) begin
                check("aw_addr", awaddr, ADDR_W'(m_aw * BL * BYTES));
                check("aw_static", {awlen, awsize, awburst, awcache, awprot, awlock, awqos, awregion, awid}, AX_STATIC);
                m_aw++;
            end
            if (wvalid && wready) begin
                check("w_data", wdata, beat_data(m_seed, m_w));
                check("w_last", wlast, (m_w % BL) == BL-1);
                check("w_strb", wstrb, {BYTES{1'b1}});
                m_w++;
            end
            if (bvalid && bready && bresp != 2'b00 && m_err < ERR_MAX) m_err++;
            if (arvalid && arready) begin
                check("ar_addr", araddr, ADDR_W'(m_ar * BL * BYTES));
                check("ar_static", {arlen, arsize, arburst, arcache, arprot, arlock, arqos, arregion, arid}, AX_STATIC);
                m_ar++;
            end
            if (rvalid && rready) begin
                m_bad = (rdata != beat_data(m_seed, m_rburst*BL + m_rbeat)) || (rresp != 2'b00) ||
                        (rlast != (m_rbeat == BL-1));
                if (m_bad && m_err < ERR_MAX) m_err++;
                if (rlast || m_rbeat == BL-1) begin m_rburst++; m_rbeat = 0; end
                else m_rbeat++;
            end
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        end
    end

    // ---------------- directed runs ----------------
    task automatic kick(logic [1:0] md, logic [31:0] sd);
        @(negedge aclk);
        m_aw = 0; m_w = 0; m_ar = 0; m_rburst = 0; m_rbeat = 0; m_err = 0; m_seed = sd;
        s_rtotal = 0; s_rburst = 0; s_bcount = 0; s_arcount = 0;
        mode = md; seed = sd; start = 1;
        @(negedge aclk);
        start = 0;
        mode = ~md; seed = ~sd;
    endtask

    task automatic run(string name, logic [1:0] md, logic [31:0] sd, int exp_err, bit extra_pulse);
        int cyc = 0;
        int exp_aw = (md == 2'd2) ? NB : NB;
        int exp_ar = (md == 2'd1) ? 0 : NB;
        if (md == 2'd2) exp_aw = 0;
        kick(md, sd);
        check({name, ":started"}, {busy, done, pass}, 3'b100);
        while (!done && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            if (extra_pulse && cyc == 8) start = 1;
            if (extra_pulse && cyc == 9) start = 0;
        end
        check({name, ":done"}, done, 1'b1);
        check({name, ":err"}, err_cnt, exp_err);
        check({name, ":pass"}, {busy, pass}, {1'b0, exp_err == 0});
        check({name, ":model_err"}, err_cnt, m_err);
        check({name, ":aw_count"}, m_aw, exp_aw);
        check({name, ":w_count"}, m_w, exp_aw * BL);
        check({name, ":ar_count"}, s_arcount, exp_ar);
        repeat (3) @(negedge aclk);
        check({name, ":done_held"}, {done, pass, err_cnt}, {1'b1, exp_err == 0, ECW'(exp_err)});
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NB*BL; i++) mem[i] = '0;
        repeat (3) @(negedge aclk);
        check("reset_status", {busy, done, pass, err_cnt}, '0);
        check("reset_valids", {awvalid, wvalid, bready, arvalid, rready}, '0);
        #2 aresetn = 1;
        @(negedge aclk);
        check("idle_status", {busy, done, pass, err_cnt, awvalid, wvalid, arvalid}, '0);

        aw_log.delete();
        run("basic", 2'd0, 32'h0, 0, 0);
        check("aw0_addr", aw_log.size() > 0 ? aw_log[0] : 64'hdead, 64'h0);
        check("aw1_addr", aw_log.size() > 1 ? aw_log[1] : 64'hdead, 64'h40);
        check("mem_beat0", mem[0], 128'h00000003_00000002_00000001_00000000);
        check("mem_beat7", mem[7], 128'h0000001f_0000001e_0000001d_0000001c);

        stall = 1;
        run("stall", 2'd0, 32'h0, 0, 0);
        run("rd_only", 2'd2, 32'h0, 0, 0);
        early_rlast = 1;
        run("early_rlast", 2'd2, 32'h0, 1, 0);
        early_rlast = 0;
        flip_beat = 5;
        run("flip_bit", 2'd0, 32'h0, 1, 0);
        flip_beat = -1;
        bresp_err0 = 1;
        run("slverr_wr_only", 2'd1, 32'h1234, 1, 0);
        bresp_err0 = 0;
        run("start_while_busy", 2'd0, 32'hdeadbeef, 0, 1);
        run("mode3", 2'd3, 32'h0badf00d, 0, 0);

        // abort in the middle of a W burst
        kick(2'd0, 32'h7);
        cyc = 0;
        while (!(wvalid && m_w >= 1) && cyc < 500) begin @(negedge aclk); cyc++; end
        check("reach_mid_w", cyc < 500, 1'b1);
        #2 aresetn = 0;
        #1 check("abort_outputs", {wvalid, awvalid, bready, arvalid, rready, busy, done, pass, err_cnt}, '0);
        repeat (3) @(negedge aclk);
        #2 aresetn = 1;
        @(negedge aclk);
        check("after_abort_idle", {busy, done}, 2'b00);
        run("after_reset", 2'd0, 32'h9, 0, 0);

        zero_data = 1;
        run("saturate", 2'd0, 32'h1, 3, 0);
        zero_data = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
